// File: rtl/bus_uart_pkg.sv
// Shared definitions for the bus-mapped UART transmitter.
package bus_uart_pkg;

  // Register offsets relative to BASE_ADDR
  localparam logic [15:0] REG_DATA   = 16'd0;
  localparam logic [15:0] REG_STATUS = 16'd1;

  // STATUS register bit positions
  localparam int unsigned STAT_FULL  = 0;
  localparam int unsigned STAT_EMPTY = 1;
  localparam int unsigned STAT_BUSY  = 2;
  localparam int unsigned STAT_OVF   = 3;

  // Transmit FSM states
  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with first-word fall-through output; push is accepted
// when full only if a pop happens in the same cycle.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             CLK,
  input  logic             R,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH
  always_ff @(posedge CLK) begin
    if (!R) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage write
  always_ff @(posedge CLK) begin
    if (R && do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/bus_uart_tx.sv
// Bus-mapped 8N1 UART transmitter: DATA register pushes into a FIFO,
// STATUS reports full/empty/busy/overflow.
module bus_uart_tx
  import bus_uart_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR  = 16'hD000,
  parameter int unsigned CLK_DIV    = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        CLK,
  input  logic        R,
  input  logic [15:0] addr_bus,
  input  logic [7:0]  data_out,
  input  logic        data_write,
  output logic [7:0]  rd_data,
  output logic        rd_sel,
  output logic        txd
);

  localparam logic [15:0] DATA_ADDR   = BASE_ADDR + REG_DATA;
  localparam logic [15:0] STATUS_ADDR = BASE_ADDR + REG_STATUS;
  localparam logic [15:0] LAST_CNT    = 16'(CLK_DIV - 1);

  tx_state_t   state, state_n;
  logic [15:0] cnt, cnt_n;
  logic [2:0]  idx, idx_n;
  logic [7:0]  shift, shift_n;
  logic        txd_n;
  logic        ovf;
  logic        pop;
  logic        push;
  logic        overflow;
  logic        ovf_clr;
  logic        fifo_full;
  logic        fifo_empty;
  logic [7:0]  fifo_dout;
  logic [7:0]  status;
  logic        last;

  assign push     = data_write && (addr_bus == DATA_ADDR);
  assign ovf_clr  = data_write && (addr_bus == STATUS_ADDR);
  assign overflow = push && fifo_full && !pop;
  assign last     = (cnt == LAST_CNT);

  sync_fifo #(
    .WIDTH(8),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .CLK  (CLK),
    .R    (R),
    .push (push),
    .pop  (pop),
    .din  (data_out),
    .dout (fifo_dout),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  // Sticky overflow flag; a same-cycle overflow beats a clearing write
  always_ff @(posedge CLK) begin
    if (!R)            ovf <= 1'b0;
    else if (overflow) ovf <= 1'b1;
    else if (ovf_clr)  ovf <= 1'b0;
  end

  // FSM, bit timer, shift register and registered serial output
  always_ff @(posedge CLK) begin
    if (!R) begin
      state <= TX_IDLE;
      cnt   <= '0;
      idx   <= '0;
      shift <= '0;
      txd   <= 1'b1;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
      shift <= shift_n;
      txd   <= txd_n;
    end
  end

  // Next-state logic; txd is derived from the next state so the
  // registered line changes exactly at state/bit boundaries
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    shift_n = shift;
    pop     = 1'b0;
    case (state)
      TX_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_n = fifo_dout;
          cnt_n   = '0;
          state_n = TX_START;
        end
      end
      TX_START: begin
        if (last) begin
          cnt_n   = '0;
          idx_n   = '0;
          state_n = TX_DATA;
        end else begin
          cnt_n = cnt + 16'd1;
        end
      end
      TX_DATA: begin
        if (last) begin
          cnt_n = '0;
          if (idx == 3'd7) begin
            state_n = TX_STOP;
          end else begin
            idx_n   = idx + 3'd1;
            shift_n = shift >> 1;
          end
        end else begin
          cnt_n = cnt + 16'd1;
        end
      end
      TX_STOP: begin
        if (last) begin
          cnt_n   = '0;
          state_n = TX_IDLE;
        end else begin
          cnt_n = cnt + 16'd1;
        end
      end
      default: state_n = TX_IDLE;
    endcase
    case (state_n)
      TX_START: txd_n = 1'b0;
      TX_DATA:  txd_n = shift_n[0];
      default:  txd_n = 1'b1;
    endcase
  end

  // Side-effect-free register read decode
  always_comb begin
    status             = '0;
    status[STAT_FULL]  = fifo_full;
    status[STAT_EMPTY] = fifo_empty;
    status[STAT_BUSY]  = (state != TX_IDLE);
    status[STAT_OVF]   = ovf;
    rd_sel  = (addr_bus == DATA_ADDR) || (addr_bus == STATUS_ADDR);
    rd_data = (addr_bus == STATUS_ADDR) ? status : 8'h00;
  end

endmodule

// File: tb/tb_bus_uart_tx.sv
// Self-checking bench for bus_uart_tx (CLK_DIV=4, FIFO_DEPTH=4).
module tb_bus_uart_tx;

  localparam logic [15:0] A_DATA = 16'hD000;
  localparam logic [15:0] A_STAT = 16'hD001;
  localparam logic [15:0] A_NONE = 16'hD002;
  localparam int          DIV    = 4;
  localparam int          DEPTH  = 4;

  logic        CLK = 1'b0;
  logic        R = 1'b0;
  logic [15:0] addr_bus = A_STAT;
  logic [7:0]  data_out = 8'h00;
  logic        data_write = 1'b0;
  logic [7:0]  rd_data;
  logic        rd_sel;
  logic        txd;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  always #5 CLK = ~CLK;

  bus_uart_tx #(
    .BASE_ADDR (16'hD000),
    .CLK_DIV   (DIV),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .CLK       (CLK),
    .R         (R),
    .addr_bus  (addr_bus),
    .data_out  (data_out),
    .data_write(data_write),
    .rd_data   (rd_data),
    .rd_sel    (rd_sel),
    .txd       (txd)
  );

  task automatic check8(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a byte queue plus a frame timeline (cycle k of 10*DIV)
  logic [7:0] mq[$];
  bit         m_busy = 0;
  int         m_k = 0;
  logic [7:0] m_byte = 8'h00;
  bit         m_ovf = 0;
  bit         chk_en = 0;

  always @(posedge CLK) begin
    bit popped;
    if (!R) begin
      mq.delete();
      m_busy = 0;
      m_k    = 0;
      m_ovf  = 0;
    end else begin
      popped = !m_busy && (mq.size() > 0);
      if (m_busy) begin
        m_k++;
        if (m_k == 10 * DIV) m_busy = 0;
      end
      if (popped) begin
        m_byte = mq.pop_front();
        m_busy = 1;
        m_k    = 0;
      end
      if (data_write && addr_bus == A_DATA) begin
        if (mq.size() < DEPTH) mq.push_back(data_out);
        else m_ovf = 1;
      end else if (data_write && addr_bus == A_STAT) begin
        m_ovf = 0;
      end
    end
  end

  function automatic logic model_txd();
    int j;
    if (!m_busy) return 1'b1;
    j = m_k / DIV;
    if (j == 0) return 1'b0;
    if (j == 9) return 1'b1;
    return m_byte[j-1];
  endfunction

  function automatic logic [7:0] model_status();
    return {4'b0, m_ovf, m_busy, mq.size() == 0, mq.size() == DEPTH};
  endfunction

  // Per-cycle comparison against the model
  always @(negedge CLK) begin
    if (chk_en) begin
      check8("txd", {7'b0, txd}, {7'b0, model_txd()});
      check8("rd_sel", {7'b0, rd_sel}, {7'b0, (addr_bus == A_DATA) || (addr_bus == A_STAT)});
      check8("rd_data", rd_data, (addr_bus == A_STAT) ? model_status() : 8'h00);
    end
  end

  task automatic drive(input logic r, input logic we, input logic [15:0] a, input logic [7:0] d);
    @(posedge CLK);
    #2;
    R          = r;
    data_write = we;
    addr_bus   = a;
    data_out   = d;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b1, 1'b0, A_STAT, 8'h00);
  endtask

  initial begin : stim
    logic [9:0] frame;
    int         busy_cnt;
    int         tries;
    int         pct;
    int         r;
    logic [7:0] wv[5];

    // Reset state, pushes ignored during reset
    @(posedge CLK);
    #2;
    chk_en = 1;
    @(negedge CLK);
    check8("status_in_reset", rd_data, 8'h02);
    drive(1'b0, 1'b1, A_DATA, 8'hFF);
    drive(1'b1, 1'b0, A_STAT, 8'h00);
    @(negedge CLK);
    check8("status_after_reset", rd_data, 8'h02);
    check8("rdsel_status", {7'b0, rd_sel}, 8'h01);
    drive(1'b1, 1'b0, A_NONE, 8'h00);
    @(negedge CLK);
    check8("rdsel_d002", {7'b0, rd_sel}, 8'h00);
    check8("rddata_d002", rd_data, 8'h00);

    // Single frame 0xA5: literal waveform and busy length
    frame    = {1'b1, 8'hA5, 1'b0};
    busy_cnt = 0;
    drive(1'b1, 1'b1, A_DATA, 8'hA5);
    for (int i = 0; i < 42; i++) begin
      drive(1'b1, 1'b0, A_STAT, 8'h00);
      @(negedge CLK);
      if (rd_data[2]) busy_cnt++;
      if (i == 0 || i == 41) check8("a5_idle_txd", {7'b0, txd}, 8'h01);
      else check8("a5_frame_txd", {7'b0, txd}, {7'b0, frame[(i-1)/DIV]});
    end
    check8("a5_busy_cycles", 8'(busy_cnt), 8'd40);

    // Five back-to-back writes: no overflow, order checked by the model
    wv = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b1, A_DATA, wv[i]);
    idle(5 * 41 + 10);
    @(negedge CLK);
    check8("five_no_ovf", rd_data, 8'h02);

    // Six writes while busy: overflow sets, STATUS write clears
    drive(1'b1, 1'b1, A_DATA, 8'h66);
    idle(3);
    for (int i = 0; i < 6; i++) drive(1'b1, 1'b1, A_DATA, 8'(8'h70 + i));
    drive(1'b1, 1'b0, A_STAT, 8'h00);
    @(negedge CLK);
    check8("ovf_set", {7'b0, rd_data[3]}, 8'h01);
    drive(1'b1, 1'b1, A_STAT, 8'h5A);
    drive(1'b1, 1'b0, A_STAT, 8'h00);
    @(negedge CLK);
    check8("ovf_cleared", {7'b0, rd_data[3]}, 8'h00);

    // Full FIFO: push coinciding with the IDLE->START pop
    idle(5 * 41 + 10);
    drive(1'b1, 1'b1, A_DATA, 8'h81);
    idle(3);
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, A_DATA, 8'(8'h90 + i));
    drive(1'b1, 1'b0, A_DATA, 8'h00);
    tries = 0;
    @(negedge CLK);
    while (m_busy && tries < 100) begin
      @(negedge CLK);
      tries++;
    end
    check8("wait_idle_bound", {7'b0, tries < 100}, 8'h01);
    data_write = 1'b1;
    data_out   = 8'hA7;
    @(posedge CLK);
    #2;
    data_write = 1'b0;
    addr_bus   = A_STAT;
    @(negedge CLK);
    check8("full_push_pop", rd_data, 8'h05);
    idle(5 * 41 + 10);

    // Reset mid-frame with two bytes queued
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, A_DATA, 8'(8'hC3 + i));
    idle(DIV * 4 + 2);
    drive(1'b0, 1'b0, A_STAT, 8'h00);
    drive(1'b1, 1'b0, A_STAT, 8'h00);
    @(negedge CLK);
    check8("abort_txd", {7'b0, txd}, 8'h01);
    check8("abort_status", rd_data, 8'h02);
    idle(60);
    @(negedge CLK);
    check8("no_more_frames", rd_data, 8'h02);

    // Randomized traffic, alternating light and heavy write load
    for (int blk = 0; blk < 6; blk++) begin
      pct = (blk % 2 == 1) ? 15 : 2;
      for (int c = 0; c < 500; c++) begin
        r = int'($urandom_range(0, 999));
        if (r < 3) drive(1'b0, 1'b0, A_STAT, 8'h00);
        else if (r < pct * 10) drive(1'b1, 1'b1, A_DATA, 8'($urandom));
        else if (r < pct * 10 + 20) drive(1'b1, 1'b1, A_STAT, 8'($urandom));
        else begin
          case ($urandom_range(0, 3))
            0:       drive(1'b1, 1'b0, A_DATA, 8'($urandom));
            1:       drive(1'b1, 1'b0, A_STAT, 8'($urandom));
            2:       drive(1'b1, 1'b0, A_NONE, 8'($urandom));
            default: drive(1'b1, 1'b0, 16'($urandom), 8'($urandom));
          endcase
        end
      end
    end
    idle(5 * 41 + 10);
    @(negedge CLK);
    chk_en = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
